// File: rtl/esm_pkg.sv
// Shared ESM selection-path types: slot index, sample word and the candidate
// buffer's output-stage state encoding.
package esm_pkg;
  localparam int ESM_BS  = 16;
  localparam int ESM_DW  = 32;
  localparam int BS_BITS = $clog2(ESM_BS);

  typedef logic [BS_BITS-1:0] slot_idx_t;
  typedef logic [ESM_DW-1:0]  sample_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;
endpackage

// File: rtl/esm_candidate_buffer_if.sv
// Handshake bundle of the candidate buffer: sample write port, slot-select
// port from the mapping table, and the sample output port.
interface esm_candidate_buffer_if #(
  parameter int BS = esm_pkg::ESM_BS,
  parameter int DW = esm_pkg::ESM_DW
) ();
  localparam int IW = $clog2(BS);

  // Every port transfers on a cycle where valid && ready at the rising edge;
  // valid never depends on ready, and a held valid keeps its payload stable.
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          sel_valid;
  logic [IW-1:0] sel_index;
  logic          sel_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    output in_valid, in_data, sel_valid, sel_index, out_ready,
    input  in_ready, sel_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, sel_valid, sel_index, out_ready,
    output in_ready, sel_ready, out_valid, out_data
  );
endinterface

// File: rtl/esm_candidate_buffer_lowest_free_enc.sv
// Priority encoder over the free slots: lowest index whose valid bit is 0.
module lowest_free_enc #(
  parameter int BS = 16
) (
  input  logic [BS-1:0]         valid,
  output logic [$clog2(BS)-1:0] free_idx,
  output logic                  found
);
  localparam int IW = $clog2(BS);

  // Scanning downward lets the lowest free slot be the last assignment.
  always_comb begin
    free_idx = '0;
    found    = 1'b0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_idx = IW'(i);
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/esm_candidate_buffer.sv
// Slot-based candidate buffer: stores samples, publishes occupancy as cand_list,
// and emits the slot picked by the mapping table. sel_err: ESM_CAND_BUF_SEL_ERR_EN.
module esm_candidate_buffer
  import esm_pkg::*;
#(
  parameter int BS = esm_pkg::ESM_BS,
  parameter int DW = esm_pkg::ESM_DW
) (
  input  logic                    clk,
  input  logic                    rst,
  esm_candidate_buffer_if.slave   bus,
  output logic [BS-1:0]           cand_list,
  output logic [$clog2(BS):0]     occupancy,
  output logic                    sel_err,
  output out_state_e              state_dbg
);
  localparam int IW = $clog2(BS);
  localparam int OW = IW + 1;
  localparam logic [OW-1:0] FULL_CNT = OW'(BS);

  logic [BS-1:0] valid_q, valid_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [DW-1:0] slot_data [BS];
  logic [DW-1:0] out_data_q;
  out_state_e    state_q, state_d;

  logic [IW-1:0] free_idx;
  logic          found;
  logic          wr_fire, sel_fire, sel_hit, out_valid_w;

  lowest_free_enc #(.BS(BS)) u_enc (
    .valid    (valid_q),
    .free_idx (free_idx),
    .found    (found)
  );

  assign out_valid_w   = (state_q == OUT_FULL);
  assign bus.in_ready  = (occ_q != FULL_CNT);
  assign bus.sel_ready = !out_valid_w || bus.out_ready;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_data_q;
  assign cand_list     = valid_q;
  assign occupancy     = occ_q;
  assign state_dbg     = state_q;

  // found always tracks in_ready; gating on it keeps a write from ever
  // landing on an occupied slot should the two disagree.
  assign wr_fire  = bus.in_valid && bus.in_ready && found;
  assign sel_fire = bus.sel_valid && bus.sel_ready;
  assign sel_hit  = sel_fire && valid_q[bus.sel_index];

  always_comb begin
    valid_d = valid_q;
    if (wr_fire) valid_d[free_idx] = 1'b1;
    if (sel_hit) valid_d[bus.sel_index] = 1'b0;
  end

  always_comb begin
    occ_d = occ_q;
    case ({wr_fire, sel_hit})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (sel_hit) state_d = OUT_FULL;
      OUT_FULL:  if (!sel_hit && bus.out_ready) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      occ_q      <= '0;
      state_q    <= OUT_EMPTY;
      out_data_q <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      state_q <= state_d;
      if (sel_hit) out_data_q <= slot_data[bus.sel_index];
    end
  end

  // Sample storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_fire) slot_data[free_idx] <= bus.in_data;
  end

`ifdef ESM_CAND_BUF_SEL_ERR_EN
  logic sel_err_q;
  logic sel_miss;

  assign sel_miss = sel_fire && !valid_q[bus.sel_index];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           sel_err_q <= 1'b0;
    else if (sel_miss) sel_err_q <= 1'b1;
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_esm_candidate_buffer.sv
// Randomized and directed bench for esm_candidate_buffer against a slot-array
// reference model with an output-stream scoreboard.
module tb_esm_candidate_buffer;
  import esm_pkg::*;

  localparam int BS = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [BS-1:0]          cand_list;
  logic [$clog2(BS):0]    occupancy;
  logic                   sel_err;
  out_state_e             state_dbg;

  esm_candidate_buffer_if #(.BS(BS), .DW(DW)) bus ();

  esm_candidate_buffer #(.BS(BS), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cand_list (cand_list),
    .occupancy (occupancy),
    .sel_err   (sel_err),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: what each slot holds, what sits in the output register.
  logic [DW-1:0] m_data [BS];
  bit            m_valid [BS];
  bit            m_ov;
  logic [DW-1:0] m_out;
  bit            m_err;
  logic [DW-1:0] exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < BS; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  function automatic logic [BS-1:0] m_mask();
    logic [BS-1:0] m = '0;
    for (int i = 0; i < BS; i++) m[i] = m_valid[i];
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BS; i++) m_valid[i] = 1'b0;
    m_ov  = 1'b0;
    m_out = '0;
    m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    chk("in_ready",  bus.in_ready,  m_count() != BS);
    chk("sel_ready", bus.sel_ready, !m_ov || bus.out_ready);
    chk("cand_list", cand_list,     m_mask());
    chk("occupancy", occupancy,     m_count());
    chk("out_valid", bus.out_valid, m_ov);
    chk("out_data",  bus.out_data,  m_out);
    chk("sel_err",   sel_err,       m_err);
    chk("state_dbg", state_dbg,     m_ov);
  endtask

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.sel_valid = 1'b0;
    bus.sel_index = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: drive, check pre-edge outputs at negedge, advance model.
  task automatic cycle(input bit iv, input logic [DW-1:0] id, input bit sv,
                       input int si, input bit orr);
    logic [DW-1:0] e;
    int  free;
    bit  ir, sr, hit;
    logic [3:0] si4;
    si4 = si[3:0];
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.sel_valid = sv;
    bus.sel_index = si4;
    bus.out_ready = orr;
    @(negedge clk);
    check_outputs();
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("handoff_q", 0, 1);
      else begin
        e = exp_q.pop_front();
        chk("handoff", bus.out_data, e);
      end
    end
    ir   = (m_count() != BS);
    free = -1;
    for (int i = BS - 1; i >= 0; i--) if (!m_valid[i]) free = i;
    sr   = !m_ov || orr;
    hit  = sv && sr && m_valid[si4];
    if (hit) begin
      m_out = m_data[si4];
      m_valid[si4] = 1'b0;
      m_ov  = 1'b1;
      exp_q.push_back(m_out);
    end else if (orr) begin
      m_ov = 1'b0;
    end
`ifdef ESM_CAND_BUF_SEL_ERR_EN
    if (sv && sr && !hit) m_err = 1'b1;
`endif
    if (iv && ir && free >= 0) begin
      m_data[free]  = id;
      m_valid[free] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive_idle();
    model_reset();
    #1;
    check_outputs();
    do_reset();

    // Fill all slots back-to-back, then try one more.
    for (int i = 0; i < BS; i++) cycle(1'b1, 32'hA0 + i, 1'b0, 0, 1'b1);
    chk("fill_cand", cand_list, 16'hFFFF);
    chk("fill_occ",  occupancy, 16);
    chk("fill_rdy",  bus.in_ready, 0);
    cycle(1'b1, 32'hEE, 1'b0, 0, 1'b1);
    chk("over_cand", cand_list, 16'hFFFF);

    cycle(1'b0, '0, 1'b1, 5, 1'b1);
    chk("sel5_data", bus.out_data, 32'hA5);
    chk("sel5_ov",   bus.out_valid, 1);
    chk("sel5_cand", cand_list, 16'hFFDF);
    chk("sel5_occ",  occupancy, 15);
    cycle(1'b1, 32'hC5, 1'b0, 0, 1'b1);
    chk("refill_cand", cand_list, 16'hFFFF);
    cycle(1'b0, '0, 1'b1, 5, 1'b1);
    chk("refill_data", bus.out_data, 32'hC5);
    cycle(1'b0, '0, 1'b0, 0, 1'b1);

    // Backpressure on the output register.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA0 + i, 1'b0, 0, 1'b1);
    cycle(1'b0, '0, 1'b1, 2, 1'b0);
    chk("bp_data",  bus.out_data, 32'hA2);
    chk("bp_srdy",  bus.sel_ready, 0);
    cycle(1'b0, '0, 1'b1, 3, 1'b0);
    chk("bp_hold",  bus.out_data, 32'hA2);
    chk("bp_cand",  cand_list, 16'h000B);
    cycle(1'b0, '0, 1'b1, 3, 1'b1);
    chk("bp_nobub_ov", bus.out_valid, 1);
    chk("bp_nobub",    bus.out_data, 32'hA3);
    cycle(1'b0, '0, 1'b0, 0, 1'b1);

    // Same-cycle write and select.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hA0 + i, 1'b0, 0, 1'b1);
    cycle(1'b1, 32'hB0, 1'b1, 0, 1'b1);
    chk("wsel_occ",  occupancy, 3);
    chk("wsel_cand", cand_list, 16'h000E);
    chk("wsel_data", bus.out_data, 32'hA0);
    cycle(1'b0, '0, 1'b0, 0, 1'b1);

    // Select of an empty slot.
    cycle(1'b0, '0, 1'b1, 9, 1'b1);
`ifdef ESM_CAND_BUF_SEL_ERR_EN
    chk("inv_err", sel_err, 1);
`else
    chk("inv_err", sel_err, 0);
`endif
    chk("inv_cand", cand_list, 16'h000E);
    chk("inv_ov",   bus.out_valid, 0);
    cycle(1'b0, '0, 1'b1, 3, 1'b1);
    chk("slot3_data", bus.out_data, 32'hB0);
    cycle(1'b0, '0, 1'b0, 0, 1'b1);

    // Random traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 50,
            $urandom_range(0, BS - 1), $urandom_range(0, 99) < 70);
    end

    // Asynchronous reset with output full and 7 slots occupied.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'hD0 + i, 1'b0, 0, 1'b1);
    cycle(1'b0, '0, 1'b1, 4, 1'b0);
    chk("pre_rst_occ", occupancy, 7);
    chk("pre_rst_ov",  bus.out_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_async_data", bus.out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hE0 + i, 1'b0, 0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1, 1'b1);
    chk("post_rst_data", bus.out_data, 32'hE1);
    cycle(1'b0, '0, 1'b0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
